// File: rtl/hack_data_memory.sv
// Hack data-memory responder: 16K RAM, 8K screen shadow, KBD register, screen write FIFO.
// Define DATAMEM_BUSERR_EN to enable the sticky bus_err detector; otherwise bus_err is tied 0.
module hack_data_memory #(
  parameter int    FIFO_DEPTH    = 4,
  parameter string RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  output logic        scr_ovf,
  output logic        bus_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [15:0] ram    [16384];
  logic [15:0] shadow [8192];
  logic [12:0] fifoAddr [FIFO_DEPTH];
  logic [15:0] fifoData [FIFO_DEPTH];

  logic [15:0] kbdReg;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0] count;
  logic [PW:0] countNext;
  logic ovfReg;

  logic isRam;
  logic isScr;
  logic isKbd;
  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  assign isRam = !addressM[14];
  assign isScr = addressM[14:13] == 2'b10;
  assign isKbd = addressM == 15'h6000;

  // Storage arrays are deliberately not reset.
  always_ff @(posedge clk) begin
    if (writeM && isRam)
      ram[addressM[13:0]] <= outM;
    if (writeM && isScr)
      shadow[addressM[12:0]] <= outM;
    if (accept) begin
      fifoAddr[wrPtr] <= addressM[12:0];
      fifoData[wrPtr] <= outM;
    end
  end

  always_comb begin
    inM = 16'h0000;
    unique case (1'b1)
      isRam:   inM = ram[addressM[13:0]];
      isScr:   inM = shadow[addressM[12:0]];
      isKbd:   inM = kbdReg;
      default: inM = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      kbdReg <= 16'h0000;
    else if (kbd_valid)
      kbdReg <= kbd_code;
  end

  assign scr_valid = count != '0;
  assign full      = count == (PW+1)'(FIFO_DEPTH);
  assign push      = writeM && isScr;
  assign pop       = scr_valid && scr_ready;
  // A pop frees the slot in time for a same-edge push when full.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign countNext = count + (PW+1)'(accept) - (PW+1)'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      ovfReg <= 1'b0;
    end else begin
      if (accept)
        wrPtr <= wrPtr + PW'(1);
      if (pop)
        rdPtr <= rdPtr + PW'(1);
      count <= countNext;
      if (drop)
        ovfReg <= 1'b1;
    end
  end

  assign scr_addr = fifoAddr[rdPtr];
  assign scr_data = fifoData[rdPtr];
  assign scr_ovf  = ovfReg;

`ifdef DATAMEM_BUSERR_EN
  logic unmapped;
  logic prevUnmapped;
  logic busErrReg;

  assign unmapped = addressM > 15'h6000;

  // A read is only trusted once the address has been held across two edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevUnmapped <= 1'b0;
      busErrReg    <= 1'b0;
    end else begin
      prevUnmapped <= unmapped;
      if ((writeM && addressM[14:13] == 2'b11) ||
          (unmapped && prevUnmapped))
        busErrReg <= 1'b1;
    end
  end

  assign bus_err = busErrReg;
`else
  assign bus_err = 1'b0;
`endif

endmodule
